// File: rtl/param_fifo.sv
// Single-clock FIFO with occupancy flags. A read has 1-cycle latency, or 0 cycles in first-word fall-through mode when FIFO_FWFT_EN is defined.
// A write while full is dropped and pulses overflow. A read while empty is dropped and pulses underflow.
module param_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          wr_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Full blocks only the write and empty blocks only the read, so the lone survivor of a collision falls out naturally
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Pointers are exactly log2(depth) wide so wrap is free
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head entry is visible before the pop; forced to zero while empty so reset shows a clean bus
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)      data_out <= '0;
    else if (rd_ok) data_out <= mem[rd_ptr];
  end
`endif

endmodule
